// File: rtl/instr_buffer_pkg.sv
// Shared constants and entry type for the fetch-to-decode instruction buffer.
package instr_buffer_pkg;

    localparam int          IB_DEPTH     = 8;
    localparam int          IB_AF_MARGIN = 2;
    localparam logic [31:0] RESET_PC     = 32'h1c00_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ib_entry_t;

endpackage

// File: rtl/ib_mem.sv
// Instruction buffer storage: one synchronous write port, one asynchronous read port.
// Contents are never reset; the owner masks stale data with its occupancy count.
module ib_mem
    import instr_buffer_pkg::*;
#(
    parameter int  DEPTH = IB_DEPTH,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [31:0]   wr_pc,
    input  logic [31:0]   wr_instr,
    input  logic [PW-1:0] raddr,
    output logic [31:0]   rd_pc,
    output logic [31:0]   rd_instr
);

    ib_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= '{pc: wr_pc, instr: wr_instr};
        end
    end

    // Combinational read gives first-word-fall-through at the buffer head.
    assign rd_pc    = mem[raddr].pc;
    assign rd_instr = mem[raddr].instr;

endmodule

// File: rtl/instr_buffer.sv
// Circular FWFT instruction buffer between fetch and decode, with registered
// almost-full backpressure, branch flush and a sticky overflow flag.
module instr_buffer
    import instr_buffer_pkg::*;
#(
    parameter int DEPTH     = IB_DEPTH,
    parameter int AF_MARGIN = IB_AF_MARGIN
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [31:0]            pc_in,
    input  logic [31:0]            instr_in,
    input  logic                   valid_in,
    input  logic                   flush,
    input  logic                   ready_ID,
    output logic [31:0]            pc_out,
    output logic [31:0]            instr_out,
    output logic                   valid_out,
    output logic                   stall_full_instr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_overflow
);

    localparam int              PW        = $clog2(DEPTH);
    localparam int              CW        = PW + 1;
    localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0]   AF_THRESH = CW'(DEPTH - AF_MARGIN);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          stall_q, stall_d;
    logic          err_q, err_d;

    logic          not_empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [31:0]   head_pc;
    logic [31:0]   head_instr;

    ib_mem #(.DEPTH(DEPTH)) u_mem (
        .clk      (clk),
        .we       (push),
        .waddr    (tail_q),
        .wr_pc    (pc_in),
        .wr_instr (instr_in),
        .raddr    (head_q),
        .rd_pc    (head_pc),
        .rd_instr (head_instr)
    );

    always_comb begin
        not_empty = (count_q != '0);
        full      = (count_q == FULL_CNT);
        valid_out = not_empty & ~flush;
        pop       = valid_out & ready_ID;
        // When full, a push is still accepted if the head leaves in the same cycle.
        push      = valid_in & ~flush & (~full | pop);

        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        stall_d   = ~flush & (count_q >= AF_THRESH);
        err_d     = err_q | (valid_in & ~flush & full & ~pop);

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // Storage is unreset, so hide it whenever the buffer is empty.
        pc_out    = not_empty ? head_pc    : '0;
        instr_out = not_empty ? head_instr : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign count            = count_q;
    assign stall_full_instr = stall_q;
    assign err_overflow     = err_q;

endmodule

// File: tb/tb_instr_buffer.sv
// Scoreboard bench for instr_buffer: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_instr_buffer;
    import instr_buffer_pkg::*;

    localparam int DEPTH = IB_DEPTH;
    localparam int AFM   = IB_AF_MARGIN;
    localparam int THR   = DEPTH - AFM;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk      = 1'b0;
    logic          rstn     = 1'b0;
    logic [31:0]   pc_in    = '0;
    logic [31:0]   instr_in = '0;
    logic          valid_in = 1'b0;
    logic          flush    = 1'b0;
    logic          ready_ID = 1'b0;
    logic [31:0]   pc_out;
    logic [31:0]   instr_out;
    logic          valid_out;
    logic          stall_full_instr;
    logic [CW-1:0] count;
    logic          err_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: occupancy, flags, and expected output order.
    ib_entry_t sb_q[$];
    ib_entry_t mon_e;
    int        m_count = 0;
    bit        m_stall = 1'b0;
    bit        m_err   = 1'b0;
    logic [31:0] next_pc;
    logic [31:0] fill_base;

    always #5 clk = ~clk;

    instr_buffer #(.DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .pc_in            (pc_in),
        .instr_in         (instr_in),
        .valid_in         (valid_in),
        .flush            (flush),
        .ready_ID         (ready_ID),
        .pc_out           (pc_out),
        .instr_out        (instr_out),
        .valid_out        (valid_out),
        .stall_full_instr (stall_full_instr),
        .count            (count),
        .err_overflow     (err_overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a buffer is a queue; it accepts a push unless it is full and nothing leaves.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_count = 0;
            m_stall = 1'b0;
            m_err   = 1'b0;
            sb_q.delete();
        end else begin
            bit m_pop;
            bit m_push;
            m_pop  = (m_count > 0) && !flush && ready_ID;
            m_push = valid_in && !flush && ((m_count < DEPTH) || m_pop);
            if (valid_in && !flush && (m_count == DEPTH) && !m_pop) m_err = 1'b1;
            m_stall = !flush && (m_count >= THR);
            if (flush) begin
                m_count = 0;
                sb_q.delete();
            end else begin
                if (m_push) begin
                    sb_q.push_back('{pc: pc_in, instr: instr_in});
                    m_count++;
                end
                if (m_pop) m_count--;
            end
        end
    end

    // Monitor: mid-cycle compare of status outputs and of every entry decode takes.
    always @(negedge clk) begin
        if (rstn) begin
            check("count", 64'(count), 64'(m_count));
            check("valid_out", 64'(valid_out), 64'((m_count > 0) && !flush));
            check("stall_full_instr", 64'(stall_full_instr), 64'(m_stall));
            check("err_overflow", 64'(err_overflow), 64'(m_err));
            if (valid_out && ready_ID) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got pc 0x%08h, expected no entry (t=%0t)", pc_out, $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("pc_out", 64'(pc_out), 64'(mon_e.pc));
                    check("instr_out", 64'(instr_out), 64'(mon_e.instr));
                    $display("pop pc=%08h instr=%08h exp_pc=%08h", pc_out, instr_out, mon_e.pc);
                end
            end
        end
    end

    task automatic drive(input bit v, input bit r, input bit f);
        valid_in = v;
        ready_ID = r;
        flush    = f;
        pc_in    = next_pc;
        instr_in = $urandom;
        if (v) next_pc = next_pc + 32'd4;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_in = 1'b0;
        ready_ID = 1'b0;
        flush    = 1'b0;
        #1;
    endtask

    task automatic drain();
        repeat (DEPTH + 1) drive(1'b0, 1'b1, 1'b0);
        idle();
        check("drain_count", 64'(count), 64'd0);
    endtask

    initial begin
        next_pc = RESET_PC;
        #12;
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_stall", 64'(stall_full_instr), 64'd0);
        check("rst_err", 64'(err_overflow), 64'd0);
        check("rst_pc_out", 64'(pc_out), 64'd0);
        check("rst_instr_out", 64'(instr_out), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Three pushes with decode stalled.
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        idle();
        check("t3_count", 64'(count), 64'd3);
        check("t3_head_pc", 64'(pc_out), 64'(RESET_PC));
        check("t3_stall", 64'(stall_full_instr), 64'd0);
        drain();

        // Fill to full; stall follows the threshold by one cycle.
        fill_base = next_pc;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            if (i == THR - 1) check("stall_at_thr", 64'(stall_full_instr), 64'd0);
            if (i == THR)     check("stall_after_thr", 64'(stall_full_instr), 64'd1);
        end
        idle();
        check("full_count", 64'(count), 64'(DEPTH));
        check("full_stall", 64'(stall_full_instr), 64'd1);

        // Simultaneous push and pop while full.
        drive(1'b1, 1'b1, 1'b0);
        idle();
        check("full_pp_count", 64'(count), 64'(DEPTH));
        check("full_pp_err", 64'(err_overflow), 64'd0);
        check("full_pp_head", 64'(pc_out), 64'(fill_base + 32'd4));

        // Push without pop while full is dropped.
        drive(1'b1, 1'b0, 1'b0);
        idle();
        check("ovf_err", 64'(err_overflow), 64'd1);
        check("ovf_count", 64'(count), 64'(DEPTH));

        // Asynchronous reset between edges with four entries held.
        repeat (4) drive(1'b0, 1'b1, 1'b0);
        idle();
        check("pre_rst_count", 64'(count), 64'd4);
        #1;
        rstn = 1'b0;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_valid_out", 64'(valid_out), 64'd0);
        check("arst_err", 64'(err_overflow), 64'd0);
        check("arst_stall", 64'(stall_full_instr), 64'd0);
        @(negedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Pointer wrap: 5 in, 5 out, then 6 streamed with decode always ready.
        repeat (5) drive(1'b1, 1'b0, 1'b0);
        repeat (5) drive(1'b0, 1'b1, 1'b0);
        repeat (6) drive(1'b1, 1'b1, 1'b0);
        drain();
        check("wrap_sb_empty", 64'(sb_q.size()), 64'd0);

        // Flush with a concurrent push.
        repeat (5) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        idle();
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid_out", 64'(valid_out), 64'd0);
        check("flush_stall", 64'(stall_full_instr), 64'd0);
        repeat (2) drive(1'b1, 1'b1, 1'b0);
        drain();

        // Randomized traffic: push-heavy phase, then pop-heavy phase.
        for (int i = 0; i < 1500; i++) begin
            if (i < 750)
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 31) == 0);
            else
                drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end
        drain();
        check("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_buffer.md
INSTR_BUFFER -- requirements
Module: instr_buffer

Interface
REQ-001 Parameter DEPTH, default 8: number of entries; power of two, at least 4.
REQ-002 Parameter AF_MARGIN, default 2: entries reserved for fetches already in flight in IF1/IF2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 pc_in  input  32  PC of the fetched instruction.
REQ-006 instr_in  input  32  fetched instruction word.
REQ-007 valid_in  input  1  push request from the fetch stage.
REQ-008 flush  input  1  EX_BR redirect; discards all buffered contents.
REQ-009 ready_ID  input  1  decode stage accepts the head entry this cycle.
REQ-010 pc_out  output  32  PC of the head entry.
REQ-011 instr_out  output  32  instruction word of the head entry.
REQ-012 valid_out  output  1  head entry is valid.
REQ-013 stall_full_instr  output  1  backpressure to IF1.
REQ-014 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-015 err_overflow  output  1  sticky flag: a push was dropped.

Function
REQ-016 Storage SHALL be a circular FIFO using head/tail pointers and count, with first-word-fall-through: pc_out and instr_out show the head entry combinationally whenever count>0.
REQ-017 valid_out SHALL equal (count != 0) & ~flush.
REQ-018 Push SHALL occur when valid_in & ~flush & (count<DEPTH): write the entry at tail, then tail+1 modulo DEPTH.
REQ-019 Pop SHALL occur when valid_out & ready_ID: head+1 modulo DEPTH.
REQ-020 count SHALL update as follows: push only, +1; pop only, -1; push and pop together, unchanged, including when count==DEPTH-1 and when count==1.
REQ-021 When count==DEPTH, a pop and a push in the same cycle SHALL both be accepted and count SHALL stay at DEPTH.
REQ-022 In that full case, a push without a pop SHALL be dropped and SHALL set err_overflow, which stays set until reset.
REQ-023 stall_full_instr SHALL be a registered output, asserted in the cycle after count becomes at least DEPTH-AF_MARGIN, and deasserted in the cycle after count falls below that threshold.
REQ-024 On flush, the next cycle SHALL have head=tail=0, count=0 and stall_full_instr=0; any push or pop in the flush cycle SHALL be ignored.
REQ-025 Pointer wrap-around SHALL be invisible at the outputs: entry order SHALL be preserved across the DEPTH-1 to 0 boundary.
REQ-026 Latency SHALL be one cycle: an entry pushed in cycle N is visible on the outputs in cycle N+1.

Reset
REQ-027 While rstn=0: head, tail and count SHALL be 0; valid_out, stall_full_instr and err_overflow SHALL be 0; pc_out and instr_out SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-029 The storage array SHALL need no reset; its contents SHALL be masked by valid_out.

Structure
REQ-030 The shared package SHALL hold IB_DEPTH, IB_AF_MARGIN, RESET_PC (32'h1c00_0000) and an ib_entry_t struct {pc[31:0], instr[31:0]}.
REQ-031 The storage array SHALL be one sub-module, ib_mem: one write port and one asynchronous read port indexed by pointer, with no reset.
REQ-032 Pointer, count, flag and backpressure logic SHALL stay in instr_buffer.

Verification
REQ-033 Reset, then 3 pushes (pc 0x1c000000/04/08) with ready_ID=0 -> count=3; the head shows pc 0x1c000000; stall_full_instr=0.
REQ-034 Fill from empty with no pops (DEPTH=8) -> stall_full_instr=1 the cycle after count reaches 6; the 9th push is dropped, err_overflow=1, and count stays 8.
REQ-035 count=8 with push and pop in the same cycle -> count stays 8; err_overflow stays 0; FIFO order is intact.
REQ-036 Push 5, pop 5, then push 6 and pop 6 with ready_ID held at 1 -> pointers wrap; PCs come out in order, without gaps or duplicates.
REQ-037 count=5 and flush=1 together with valid_in=1 -> the next cycle has count=0, valid_out=0 and stall_full_instr=0; the pushed entry never appears.
REQ-038 rstn pulsed low between clock edges with count=4 -> count=0 and valid_out=0 immediately; err_overflow is cleared.
